cardinal_input_port: RTL and testbench
======================================

CARDINAL_INPUT_PORT -- requirements
Module: cardinal_input_port

Interface
REQ-001 SHALL have parameter HOP_LSB, default 48, giving the LSB of the 8-bit hop-count field in the packet.
REQ-002 SHALL have parameter DIR_BIT, default 62, giving the bit index of the direction flag (0=cw, 1=ccw).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port polarity  input  1  router-wide even/odd cycle phase.
REQ-006 SHALL have port si  input  1  upstream valid (NIC net_so or neighbour).
REQ-007 SHALL have port ri  output  1  ready to upstream.
REQ-008 SHALL have port di  input  64  upstream packet.
REQ-009 SHALL have port req_cw  output  1  request to the clockwise output port.
REQ-010 SHALL have port req_ccw  output  1  request to the counter-clockwise output port.
REQ-011 SHALL have port req_pe  output  1  request to the local PE output port.
REQ-012 SHALL have port gnt  input  1  grant from the arbiter of the requested output.
REQ-013 SHALL have port dout  output  64  forwarded packet.
REQ-014 SHALL have port vc_full  output  2  occupancy of VC0/VC1, for status and debug.

Function
REQ-015 SHALL hold two single-entry virtual-channel buffers, VC0 and VC1, each with its own full flag.
REQ-016 External side: ri SHALL be combinational and equal to ~full[polarity].
REQ-017 On a clock edge where si && ri, di SHALL be stored unchanged into VC[polarity], and full[polarity] SHALL be set.
REQ-018 si while ri=0 SHALL be ignored, with no state change.
REQ-019 Internal side: the forwarding VC SHALL be o = ~polarity, so that the write VC and forward VC never coincide.
REQ-020 If full[o], exactly one request SHALL be asserted: req_pe when hop field == 0; otherwise req_cw when the direction bit = 0 and req_ccw when the direction bit = 1.
REQ-021 If full[o]=0, all three requests SHALL be 0.
REQ-022 Requests and dout SHALL be combinational from VC[o].
REQ-023 dout SHALL equal VC[o] with the hop field decremented by 1 when hop != 0, and unchanged when hop == 0 (no wrap to 8'hFF); all other bits, including bit 63, SHALL pass unchanged.
REQ-024 dout SHALL be 0 when full[o]=0.
REQ-025 On a clock edge where gnt && any request is high, full[o] SHALL clear; the stored data need not be cleared.
REQ-026 gnt with no request SHALL be ignored.
REQ-027 A request not granted SHALL persist while the VC stays full; when polarity toggles, forwarding moves to the other VC and the ungranted packet is re-presented on its next phase.
REQ-028 A write to VC[p] and a grant-clear of VC[~p] in the same cycle SHALL both take effect.
REQ-029 Forwarding latency SHALL be a minimum of one cycle: accepted on phase p, requested on the next phase.
REQ-030 Packet order within one VC SHALL be preserved trivially (depth 1); no ordering is guaranteed across VCs.

Reset
REQ-031 When reset=0, both full flags SHALL clear immediately and both buffers SHALL clear to 0, regardless of clk.
REQ-032 While in reset, ri SHALL follow ~full[polarity] = 1, requests SHALL be 0, dout SHALL be 0, and vc_full SHALL be 2'b00.
REQ-033 Reset asserted mid-transfer SHALL drop any buffered packet with no request outstanding afterwards.
REQ-034 Deassertion of reset SHALL take effect on the next rising edge; the first accept is possible on that edge.

Verification
REQ-035 Scenario: polarity=0, si=1, di=64'h0002_0000_0000_00AA (hop=2, dir=0) -> VC0 full, ri=0 while polarity=0; next cycle (polarity=1) req_cw=1, dout hop=1; gnt=1 -> vc_full=2'b00.
REQ-036 Scenario: packet with hop=0, dir=1 -> req_pe=1 only, req_ccw=0, dout equals the stored packet unchanged.
REQ-037 Scenario: fill VC0 on phase 0 and VC1 on phase 1 with gnt=0 -> ri=0 on both phases, requests alternate per phase, no overwrite; then grant each on its phase -> both empty.
REQ-038 Scenario: same cycle, write VC1 (polarity=1) and gnt for VC0 -> vc_full goes 2'b01 -> 2'b10.
REQ-039 Scenario: assert reset asynchronously with both VCs full between edges -> vc_full=0, requests=0 and dout=0 without a clock edge; ri=1.
REQ-040 Scenario: gnt=1 with both VCs empty, and si=1 while ri=0 -> no state change, no request asserted.

Source files
------------

// File: rtl/cardinal_input_port.sv
// Ring-router input port: two single-entry virtual channels written and
// forwarded on opposite phases of the router-wide polarity signal.
module cardinal_input_port #(
  parameter int HOP_LSB = 48,
  parameter int DIR_BIT = 62
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        polarity,
  input  logic        si,
  output logic        ri,
  input  logic [63:0] di,
  output logic        req_cw,
  output logic        req_ccw,
  output logic        req_pe,
  input  logic        gnt,
  output logic [63:0] dout,
  output logic [1:0]  vc_full
);

  logic [1:0]  full_q, full_d;
  logic [63:0] vc0_q, vc0_d;
  logic [63:0] vc1_q, vc1_d;

  logic        fwd_vc;
  logic        fwd_full;
  logic [63:0] fwd_data;
  logic [7:0]  fwd_hop;
  logic        fwd_dir;
  logic        accept;
  logic        any_req;

  // The forwarding VC is always the one not being written this phase.
  always_comb begin
    fwd_vc   = ~polarity;
    fwd_full = full_q[fwd_vc];
    fwd_data = fwd_vc ? vc1_q : vc0_q;
    fwd_hop  = fwd_data[HOP_LSB +: 8];
    fwd_dir  = fwd_data[DIR_BIT];
    ri       = ~full_q[polarity];
    accept   = si & ri;
  end

  always_comb begin
    req_cw  = 1'b0;
    req_ccw = 1'b0;
    req_pe  = 1'b0;
    dout    = '0;
    if (fwd_full) begin
      dout = fwd_data;
      if (fwd_hop == 8'd0) begin
        req_pe = 1'b1;
      end else begin
        dout[HOP_LSB +: 8] = fwd_hop - 8'd1;
        if (fwd_dir) req_ccw = 1'b1;
        else         req_cw  = 1'b1;
      end
    end
    any_req = req_cw | req_ccw | req_pe;
  end

  // Write and grant-clear target different VCs, so both can apply together.
  always_comb begin
    full_d = full_q;
    vc0_d  = vc0_q;
    vc1_d  = vc1_q;
    if (accept) begin
      full_d[polarity] = 1'b1;
      if (polarity) vc1_d = di;
      else          vc0_d = di;
    end
    if (gnt && any_req) begin
      full_d[fwd_vc] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= '0;
      vc0_q  <= '0;
      vc1_q  <= '0;
    end else begin
      full_q <= full_d;
      vc0_q  <= vc0_d;
      vc1_q  <= vc1_d;
    end
  end

  assign vc_full = full_q;

endmodule

// File: tb/tb_cardinal_input_port.sv
// Bench for cardinal_input_port: directed vector table, reset corner case,
// then randomized traffic checked against a behavioural VC model.
module tb_cardinal_input_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        polarity;
  logic        si;
  logic        ri;
  logic [63:0] di;
  logic        req_cw, req_ccw, req_pe;
  logic        gnt;
  logic [63:0] dout;
  logic [1:0]  vc_full;

  int passed_checks = 0;
  int total_checks  = 0;

  bit          m_full [2];
  logic [63:0] m_data [2];

  typedef struct {
    logic        pol;
    logic        s;
    logic [63:0] d;
    logic        g;
    logic        exp_ri;
    logic [2:0]  exp_req;
    logic [63:0] exp_dout;
    logic [1:0]  exp_vc;
  } vec_t;

  vec_t vecs [14];

  localparam logic [63:0] PKT_A  = 64'h0002_0000_0000_00AA;
  localparam logic [63:0] PKT_AF = 64'h0001_0000_0000_00AA;
  localparam logic [63:0] PKT_B  = 64'h4000_0000_0000_0055;
  localparam logic [63:0] PKT_C  = 64'h4005_0000_0000_1234;
  localparam logic [63:0] PKT_CF = 64'h4004_0000_0000_1234;
  localparam logic [63:0] PKT_D  = 64'h8003_0000_DEAD_BEEF;
  localparam logic [63:0] PKT_DF = 64'h8002_0000_DEAD_BEEF;

  cardinal_input_port #(.HOP_LSB(48), .DIR_BIT(62)) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .si       (si),
    .ri       (ri),
    .di       (di),
    .req_cw   (req_cw),
    .req_ccw  (req_ccw),
    .req_pe   (req_pe),
    .gnt      (gnt),
    .dout     (dout),
    .vc_full  (vc_full)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Forwarded view of a stored packet: hop counts down and saturates at 0.
  function automatic logic [63:0] forwarded(input logic [63:0] pkt);
    if (pkt[55:48] == 8'd0) return pkt;
    return pkt - (64'd1 << 48);
  endfunction

  function automatic logic [2:0] expected_req(input logic [63:0] pkt);
    if (pkt[55:48] == 8'd0) return 3'b001;
    return pkt[62] ? 3'b010 : 3'b100;
  endfunction

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0;
    m_data[0] = '0; m_data[1] = '0;
  endtask

  // Model update using the inputs present just before the rising edge.
  task automatic model_step(input logic p, input logic s, input logic [63:0] d, input logic g);
    int o;
    bit acc;
    o   = p ? 0 : 1;
    acc = s && !m_full[p];
    if (g && m_full[o]) m_full[o] = 0;
    if (acc) begin
      m_full[p] = 1;
      m_data[p] = d;
    end
  endtask

  task automatic check_output(input string tag);
    int o;
    logic [2:0]  ereq;
    logic [63:0] edout;
    o     = polarity ? 0 : 1;
    ereq  = m_full[o] ? expected_req(m_data[o]) : 3'b000;
    edout = m_full[o] ? forwarded(m_data[o]) : 64'd0;
    check_value({tag, " ri"},   {63'd0, ri}, {63'd0, !m_full[polarity]});
    check_value({tag, " req"},  {61'd0, req_cw, req_ccw, req_pe}, {61'd0, ereq});
    check_value({tag, " dout"}, dout, edout);
  endtask

  task automatic apply_stimulus(input logic p, input logic s, input logic [63:0] d, input logic g);
    @(negedge clk);
    polarity = p; si = s; di = d; gnt = g;
    #1;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_step(polarity, si, di, gnt);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, PKT_A, 1'b0, 1'b1, 3'b000, 64'd0,  2'b01};
    vecs[1]  = '{1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 3'b100, PKT_AF, 2'b01};
    vecs[2]  = '{1'b0, 1'b1, PKT_B, 1'b0, 1'b0, 3'b000, 64'd0,  2'b01};
    vecs[3]  = '{1'b1, 1'b0, 64'd0, 1'b1, 1'b1, 3'b100, PKT_AF, 2'b00};
    vecs[4]  = '{1'b1, 1'b0, 64'd0, 1'b1, 1'b1, 3'b000, 64'd0,  2'b00};
    vecs[5]  = '{1'b0, 1'b1, PKT_B, 1'b0, 1'b1, 3'b000, 64'd0,  2'b01};
    vecs[6]  = '{1'b1, 1'b1, PKT_C, 1'b0, 1'b1, 3'b001, PKT_B,  2'b11};
    vecs[7]  = '{1'b0, 1'b1, PKT_D, 1'b0, 1'b0, 3'b010, PKT_CF, 2'b11};
    vecs[8]  = '{1'b1, 1'b1, PKT_D, 1'b0, 1'b0, 3'b001, PKT_B,  2'b11};
    vecs[9]  = '{1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 3'b010, PKT_CF, 2'b01};
    vecs[10] = '{1'b1, 1'b0, 64'd0, 1'b1, 1'b1, 3'b001, PKT_B,  2'b00};
    vecs[11] = '{1'b0, 1'b1, PKT_D, 1'b0, 1'b1, 3'b000, 64'd0,  2'b01};
    vecs[12] = '{1'b1, 1'b1, PKT_A, 1'b1, 1'b1, 3'b100, PKT_DF, 2'b10};
    vecs[13] = '{1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 3'b100, PKT_AF, 2'b00};

    reset = 1'b0; polarity = 1'b0; si = 1'b0; di = '0; gnt = 1'b0;
    model_reset();
    #12;
    check_value("reset ri",      {63'd0, ri}, 64'd1);
    check_value("reset vc_full", {62'd0, vc_full}, 64'd0);
    check_value("reset req",     {61'd0, req_cw, req_ccw, req_pe}, 64'd0);
    check_value("reset dout",    dout, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed vectors: outputs before the edge, occupancy after it.
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].pol, vecs[i].s, vecs[i].d, vecs[i].g);
      check_value($sformatf("vec%0d ri", i),   {63'd0, ri}, {63'd0, vecs[i].exp_ri});
      check_value($sformatf("vec%0d req", i),  {61'd0, req_cw, req_ccw, req_pe}, {61'd0, vecs[i].exp_req});
      check_value($sformatf("vec%0d dout", i), dout, vecs[i].exp_dout);
      clock_edge();
      check_value($sformatf("vec%0d vc_full", i), {62'd0, vc_full}, {62'd0, vecs[i].exp_vc});
    end

    // Asynchronous reset with both VCs full, between clock edges.
    apply_stimulus(1'b0, 1'b1, PKT_A, 1'b0);
    clock_edge();
    apply_stimulus(1'b1, 1'b1, PKT_C, 1'b0);
    clock_edge();
    check_value("prefill vc_full", {62'd0, vc_full}, 64'd3);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_value("async vc_full", {62'd0, vc_full}, 64'd0);
    check_value("async req",     {61'd0, req_cw, req_ccw, req_pe}, 64'd0);
    check_value("async dout",    dout, 64'd0);
    check_value("async ri",      {63'd0, ri}, 64'd1);
    polarity = 1'b0;
    #1;
    check_value("async req p0",  {61'd0, req_cw, req_ccw, req_pe}, 64'd0);
    @(negedge clk);
    si = 1'b0;
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b1, PKT_D, 1'b0);
    clock_edge();
    check_value("first accept vc_full", {62'd0, vc_full}, 64'd1);
    apply_stimulus(1'b1, 1'b0, 64'd0, 1'b0);
    check_output("post-reset fwd");

    // Randomized traffic against the behavioural model.
    for (int i = 0; i < 400; i++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: d[55:48] = 8'd0;
        1: d[55:48] = 8'd1;
        default: ;
      endcase
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d,
                     1'($urandom_range(0, 2) != 0));
      check_output($sformatf("rand%0d", i));
      clock_edge();
      check_value($sformatf("rand%0d vc_full", i), {62'd0, vc_full},
                  {62'd0, 1'(m_full[1]), 1'(m_full[0])});
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
